// File: rtl/string_text_renderer.sv
// string_text_renderer
//   Three-stage pixel pipeline that renders lines of packed character codes
//   as a text overlay. Stage 1 maps the pixel into the text box and drives
//   the string ROM line address, stage 2 picks the character code and drives
//   the font ROM, and stage 3 turns the returned glyph row into one bit per
//   pixel. One pixel per clock, fixed latency of 3 clocks, no stalls.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   pix_x, pix_y  current pixel coordinate
//   pix_valid     pixel is in active video
//   rom_addr      line address to the string ROM (0 outside the box)
//   rom_string    packed line returned combinationally, slot 0 in the MSBs
//   font_code     character code to the font ROM (BLANK_CODE outside the box)
//   font_row      glyph row to the font ROM (0 outside the box)
//   font_bits     glyph row from the font ROM, bit 7 = leftmost column
//   text_on       pixel is a lit glyph pixel
//   text_valid    pix_valid delayed by 3 clocks
module string_text_renderer #(
  parameter int STRING_NUM = 13,
  parameter int MAX_CHAR   = 11,
  parameter int CHAR_WIDTH = 5,
  parameter int BLANK_CODE = 31,
  parameter int SCALE_LOG2 = 1,
  parameter int ORIGIN_X   = 64,
  parameter int ORIGIN_Y   = 48,
  parameter int COORD_W    = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  input  logic                           pix_valid,
  output logic [$clog2(STRING_NUM+1)-1:0] rom_addr,
  input  logic [CHAR_WIDTH*MAX_CHAR-1:0] rom_string,
  output logic [CHAR_WIDTH-1:0]          font_code,
  output logic [2:0]                     font_row,
  input  logic [7:0]                     font_bits,
  output logic                           text_on,
  output logic                           text_valid
);

  localparam int ADDR_W = $clog2(STRING_NUM + 1);
  localparam int CIDX_W = $clog2(MAX_CHAR);
  localparam int SCALE  = 1 << SCALE_LOG2;
  localparam logic [COORD_W:0]    BOX_W = (COORD_W + 1)'(MAX_CHAR * 8 * SCALE);
  localparam logic [COORD_W:0]    BOX_H = (COORD_W + 1)'(STRING_NUM * 16 * SCALE);
  localparam logic [CHAR_WIDTH-1:0] BLANK = CHAR_WIDTH'(BLANK_CODE);

  // Box-relative coordinates; the extra top bit is the sign.
  logic [COORD_W:0] relx, rely;
  logic             in_box;

  assign relx = {1'b0, pix_x} - (COORD_W + 1)'(ORIGIN_X);
  assign rely = {1'b0, pix_y} - (COORD_W + 1)'(ORIGIN_Y);
  assign in_box = pix_valid && !relx[COORD_W] && !rely[COORD_W] &&
                  (relx < BOX_W) && (rely < BOX_H);

  // Stage 1
  logic [ADDR_W-1:0] s1_line;
  logic [CIDX_W-1:0] s1_char;
  logic [2:0]        s1_grow, s1_gcol;
  logic              s1_in_glyph, s1_in_box, s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_line     <= '0;
      s1_char     <= '0;
      s1_grow     <= '0;
      s1_gcol     <= '0;
      s1_in_glyph <= 1'b0;
      s1_in_box   <= 1'b0;
      s1_valid    <= 1'b0;
    end else begin
      // Power-of-two geometry: every divide is a bit-field pick.
      s1_line     <= rely[4 + SCALE_LOG2 +: ADDR_W];
      s1_in_glyph <= ~rely[3 + SCALE_LOG2];
      s1_char     <= relx[3 + SCALE_LOG2 +: CIDX_W];
      s1_grow     <= rely[SCALE_LOG2 +: 3];
      s1_gcol     <= relx[SCALE_LOG2 +: 3];
      s1_in_box   <= in_box;
      s1_valid    <= pix_valid;
    end
  end

  assign rom_addr = s1_in_box ? s1_line : '0;

  // Character slot select; slot 0 (leftmost on screen) is the top field.
  logic [CHAR_WIDTH-1:0] sel_code;

  always_comb begin
    sel_code = BLANK;
    for (int i = 0; i < MAX_CHAR; i++) begin
      if (s1_char == CIDX_W'(i))
        sel_code = rom_string[CHAR_WIDTH*(MAX_CHAR-i)-1 -: CHAR_WIDTH];
    end
  end

  // Stage 2
  logic [CHAR_WIDTH-1:0] s2_code;
  logic [2:0]            s2_grow, s2_gcol;
  logic                  s2_in_glyph, s2_in_box, s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_code     <= BLANK;
      s2_grow     <= '0;
      s2_gcol     <= '0;
      s2_in_glyph <= 1'b0;
      s2_in_box   <= 1'b0;
      s2_valid    <= 1'b0;
    end else begin
      s2_code     <= sel_code;
      s2_grow     <= s1_grow;
      s2_gcol     <= s1_gcol;
      s2_in_glyph <= s1_in_glyph;
      s2_in_box   <= s1_in_box;
      s2_valid    <= s1_valid;
    end
  end

  assign font_code = s2_in_box ? s2_code : BLANK;
  assign font_row  = s2_in_box ? s2_grow : 3'd0;

  // Stage 3. in_box already implies pix_valid, so text_on is never set
  // without text_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      text_on    <= 1'b0;
      text_valid <= 1'b0;
    end else begin
      text_on    <= s2_valid && s2_in_box && s2_in_glyph && (s2_code != BLANK) &&
                    font_bits[3'd7 - s2_gcol];
      text_valid <= s2_valid;
    end
  end

endmodule

// File: tb/tb_string_text_renderer.sv
module tb_string_text_renderer;

  localparam int OX = 64;
  localparam int OY = 48;
  localparam int BW = 176;   // 11 chars * 8 px * scale 2
  localparam int BH = 416;   // 13 lines * 16 rows * scale 2

  logic        clk;
  logic        rst;
  logic [9:0]  pix_x, pix_y;
  logic        pix_valid;
  logic [3:0]  rom_addr;
  logic [54:0] rom_string;
  logic [4:0]  font_code;
  logic [2:0]  font_row;
  logic [7:0]  font_bits;
  logic        text_on;
  logic        text_valid;

  string_text_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .rom_addr   (rom_addr),
    .rom_string (rom_string),
    .font_code  (font_code),
    .font_row   (font_row),
    .font_bits  (font_bits),
    .text_on    (text_on),
    .text_valid (text_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // String ROM and font ROM models
  logic [54:0] rom_table [0:15];
  logic [7:0]  font_pat;

  always_comb rom_string = rom_table[rom_addr];
  assign font_bits = font_pat;

  typedef struct {
    int    due;
    int    a;
    int    b;
    string tag;
  } ent_t;

  ent_t q_addr[$];
  ent_t q_font[$];
  ent_t q_out[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int field(input int line, input int c);
    logic [54:0] w;
    w = rom_table[line];
    w = w >> (5 * (10 - c));
    return int'(w[4:0]);
  endfunction

  task automatic step(input int x, input int y, input bit v, input bit r, input string tag);
    int rx, ry, line, c, grow, gcol, code;
    bit ib, ing, on;
    ent_t e;
    @(negedge clk);
    while (q_addr.size() > 0 && q_addr[0].due == cyc) begin
      e = q_addr.pop_front();
      check($sformatf("%s_rom_addr@%0d", e.tag, cyc), 32'(rom_addr), e.a);
    end
    while (q_font.size() > 0 && q_font[0].due == cyc) begin
      e = q_font.pop_front();
      check($sformatf("%s_font_code@%0d", e.tag, cyc), 32'(font_code), e.a);
      check($sformatf("%s_font_row@%0d", e.tag, cyc), 32'(font_row), e.b);
    end
    while (q_out.size() > 0 && q_out[0].due == cyc) begin
      e = q_out.pop_front();
      check($sformatf("%s_text_valid@%0d", e.tag, cyc), 32'(text_valid), e.a);
      check($sformatf("%s_text_on@%0d", e.tag, cyc), 32'(text_on), e.b);
    end

    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_valid = v;
    rst       = r;

    // A reset edge wipes everything still in flight.
    if (r) begin
      foreach (q_addr[i]) begin q_addr[i].a = 0; q_addr[i].b = 0; end
      foreach (q_font[i]) begin q_font[i].a = 31; q_font[i].b = 0; end
      foreach (q_out[i])  begin q_out[i].a = 0; q_out[i].b = 0; end
    end

    rx   = x - OX;
    ry   = y - OY;
    ib   = v && rx >= 0 && rx < BW && ry >= 0 && ry < BH;
    line = ry / 32;
    c    = rx / 16;
    grow = (ry / 2) % 8;
    gcol = (rx / 2) % 8;
    ing  = ((ry / 16) % 2) == 0;
    code = ib ? field(line, c) : 31;
    on   = ib && ing && code != 31 && font_pat[7 - gcol];

    if (r) begin
      q_addr.push_back('{cyc + 1, 0, 0, tag});
      q_font.push_back('{cyc + 2, 31, 0, tag});
      q_out.push_back('{cyc + 3, 0, 0, tag});
    end else begin
      q_addr.push_back('{cyc + 1, ib ? line : 0, 0, tag});
      q_font.push_back('{cyc + 2, code, ib ? grow : 0, tag});
      q_out.push_back('{cyc + 3, int'(v), int'(on), tag});
    end
    cyc++;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, "flush");
  endtask

  // Font output must stay constant while a pixel is in flight.
  task automatic set_font(input logic [7:0] p);
    flush(3);
    font_pat = p;
  endtask

  initial begin
    int code;
    logic [54:0] w;
    rst       = 1'b1;
    pix_x     = '0;
    pix_y     = '0;
    pix_valid = 1'b0;
    font_pat  = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      w = '0;
      for (int c = 0; c < 11; c++) begin
        code = (i < 13) ? (i * 3 + c + 1) % 31 : 0;
        if (i == 0 && c == 10) code = 13;
        if (i == 0 && c == 5)  code = 31;
        w[5 * (10 - c) +: 5] = 5'(code);
      end
      rom_table[i] = w;
    end

    // Reset with pixels streaming, then release
    for (int i = 0; i < 4; i++)  step(64 + i, 48, 1'b1, 1'b1, "rst_stream");
    for (int i = 4; i < 10; i++) step(64 + i, 48, 1'b1, 1'b0, "post_rst");

    set_font(8'h80);
    step(64, 48, 1'b1, 1'b0, "origin");

    set_font(8'h01);
    step(239, 63, 1'b1, 1'b0, "corner_01");
    set_font(8'hFE);
    step(239, 63, 1'b1, 1'b0, "corner_FE");

    set_font(8'hFF);
    step(100, 64, 1'b1, 1'b0, "gap");
    step(150, 48, 1'b1, 1'b0, "blank_char");
    step(100, 80, 1'b1, 1'b0, "line1");
    step(63, 48, 1'b1, 1'b0, "left_edge");
    step(240, 48, 1'b1, 1'b0, "right_edge");
    step(64, 47, 1'b1, 1'b0, "top_edge");
    step(64, 464, 1'b1, 1'b0, "bottom_edge");
    step(100, 463, 1'b1, 1'b0, "last_gap");
    step(64, 48, 1'b0, 1'b0, "invalid");
    step(200, 300, 1'b1, 1'b0, "mid_box");

    for (int x = 64; x < 240; x++) step(x, 48, 1'b1, 1'b0, "stream");
    for (int x = 64; x < 180; x++)
      step(x, 60, 1'b1, (x >= 150 && x < 153), "stream_rst");

    flush(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/string_text_renderer.md
Name: string_text_renderer

Overview:
- Pixel-pipelined text overlay that sits directly downstream of the string ROM.
- Maps each incoming VGA pixel coordinate to a text line and character slot, and drives the string ROM address for that line.
- Selects the 5-bit character code from the returned packed string, fetches the glyph row from the font ROM, and outputs one text-on bit per pixel.
- Fully pipelined: throughput 1 pixel/clock, fixed latency 3 clocks; output feeds the VGA colour mux.

Parameters:
- STRING_NUM, 13: number of text lines; line i is ROM address i.
- MAX_CHAR, 11: characters per line.
- CHAR_WIDTH, 5: bits per character code.
- BLANK_CODE, 31: code rendered as background, never lit.
- SCALE_LOG2, 1: glyph magnification = 2^SCALE_LOG2; legal values 0..2.
- ORIGIN_X, 64: screen x of the text box left edge.
- ORIGIN_Y, 48: screen y of the text box top edge.
- COORD_W, 10: width of pixel coordinates.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pix_x  in  COORD_W  current pixel column
- pix_y  in  COORD_W  current pixel row
- pix_valid  in  1  pixel is in active video
- rom_addr  out  clog2(STRING_NUM+1)  line address to string ROM
- rom_string  in  CHAR_WIDTH*MAX_CHAR  packed string returned combinationally for rom_addr
- font_code  out  CHAR_WIDTH  character code to font ROM
- font_row  out  3  glyph row 0..7 to font ROM
- font_bits  in  8  glyph row returned combinationally; bit 7 = leftmost column
- text_on  out  1  pixel is a lit glyph pixel
- text_valid  out  1  pix_valid delayed by 3 clocks

Behaviour:
- Glyph geometry:
  - Glyph cell is 8x8, scaled by S = 2^SCALE_LOG2.
  - Line pitch is 16*S rows; the glyph occupies the top 8*S rows and the remaining 8*S rows are a gap.
  - All divides are shifts; no divider or multiplier beyond constants.
- Text box:
  - relx = pix_x - ORIGIN_X, rely = pix_y - ORIGIN_Y, computed at COORD_W+1 bits signed.
  - in_box requires pix_valid, relx in [0, MAX_CHAR*8*S), and rely in [0, STRING_NUM*16*S).
  - Negative rel values are not in the box.
- Stage 1, registered on the clock after the input pixel:
  - line = rely >> (4+SCALE_LOG2)
  - in_glyph = bit (3+SCALE_LOG2) of rely is 0
  - char_idx = relx >> (3+SCALE_LOG2)
  - grow = (rely >> SCALE_LOG2) & 7
  - gcol = (relx >> SCALE_LOG2) & 7
  - Also registers in_box and pix_valid.
  - rom_addr is driven from the stage-1 line register; it is 0 when not in_box.
- Stage 2, registered:
  - code = rom_string[CHAR_WIDTH*(MAX_CHAR-char_idx)-1 -: CHAR_WIDTH], i.e. char slot 0 (leftmost on screen) is the most significant field.
  - grow, gcol, in_box and in_glyph are passed along with the code.
  - font_code and font_row are driven from the stage-2 registers.
  - When not in_box, font_code = BLANK_CODE and font_row = 0.
- Stage 3, registered:
  - text_on = in_box & in_glyph & (code != BLANK_CODE) & font_bits[7-gcol].
  - text_valid = pix_valid delayed by 3 clocks.
  - text_on is forced to 0 whenever text_valid is 0.
- Latency and throughput:
  - The pixel presented at cycle n produces outputs at cycle n+3.
  - There are no stalls and no backpressure; back-to-back pixels stream every clock.
- Reset:
  - While rst=1, all pipeline registers clear: text_on=0, text_valid=0, rom_addr=0, font_code=BLANK_CODE, font_row=0.
  - Reset asserted mid-line discards every in-flight pixel.
  - After rst falls, the first valid output appears 3 clocks after the first pixel sampled with rst=0.
- Boundaries:
  - Last column (relx = MAX_CHAR*8*S-1) is char MAX_CHAR-1, gcol 7.
  - relx = MAX_CHAR*8*S is out of box.
  - Last line's gap rows are in the box but never lit.
  - An out-of-range char_idx cannot occur when in_box.

Test Plan:
- Reset: rst=1 for 4 clocks with pix_valid=1 streaming -> text_valid=0, text_on=0, font_code=31 throughout; the first text_valid=1 appears 3 clocks after the first pixel sampled with rst=0.
- Origin pixel (64,48), pix_valid=1, font model returns 8'h80 -> rom_addr=0 at +1; font_code = rom_string[54:50] and font_row=0 at +2; text_on=1, text_valid=1 at +3.
- Far corner of glyph (239,63) with line-0 string whose last char is code 13 -> font_code=13, font_row=7; gcol=7 so text_on=font_bits[0]; check both font_bits=8'h01 -> 1 and 8'hFE -> 0.
- Gap and blank: (100,64) (rely=16, gap) with font_bits=8'hFF -> text_on=0; a pixel on a BLANK_CODE char with font_bits=8'hFF -> text_on=0; (100,80) (line 1) -> rom_addr=1.
- Box edges: (63,48), (240,48), (64,47), (64,464) -> text_on=0 with font_bits=8'hFF; pix_valid=0 at (64,48) -> text_valid=0, text_on=0.
- Streaming: x=64..239 on y=48 consecutively, all ones font -> text_on for cycle n+3 matches the model for pixel n, no bubbles; assert rst at x=150 -> outputs 0 from the next clock, in-flight pixels dropped.
